// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared definitions for the FIFO read-side controller.
//   - rdr_state_e : controller state encoding (IDLE/REQ/WAIT/HOLD)
//   - FIFO_DEPTH  : depth of the FIFO being drained
//   - DEF_DATA_W / DEF_CNT_W : default data and occupancy widths
//   - wait_cnt_t  : read-latency wait counter type
package fifo_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DEF_DATA_W = 32;
  // Occupancy must represent 0..FIFO_DEPTH inclusive.
  localparam int unsigned DEF_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } rdr_state_e;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/fifo_rdr_ns.sv
// fifo_rdr_ns: combinational next-state logic for fifo_reader.
// Ports:
//   state           in   current controller state
//   enable          in   allow new reads to start
//   clear           in   synchronous abort, overrides every transition
//   fifo_data_count in   FIFO occupancy
//   out_ready       in   downstream accepts the held word
//   wait_cnt        in   remaining read-latency cycles
//   next_state      out  state for the next clock edge
module fifo_rdr_ns
  import fifo_reader_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  rdr_state_e       state,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] fifo_data_count,
  input  logic             out_ready,
  input  wait_cnt_t        wait_cnt,
  output rdr_state_e       next_state
);

  logic has_data;

  always_comb begin
    has_data   = (fifo_data_count != '0);
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (enable && has_data) next_state = REQ;
        REQ:  next_state = WAIT;
        // Data is captured in the last wait cycle, so HOLD follows directly.
        WAIT: if (wait_cnt == wait_cnt_t'(1)) next_state = HOLD;
        HOLD: if (out_ready) next_state = (enable && has_data) ? REQ : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: consumer-side controller for the 8-deep FIFO. Issues one
// rd_en pulse at a time, captures fifo_dout after RD_LATENCY cycles and
// presents it on a valid/ready stream. All outputs are registered.
// Optional feature macro: FIFO_RDR_CNT_EN adds the 16-bit rd_count port
// (accepted-word counter, wrapping, cleared by reset_n and clear).
// Ports:
//   clk, reset_n      clock (rising) / async active-low reset
//   enable            allow new reads to start
//   clear             synchronous abort (also drives the FIFO opclear)
//   fifo_data_count   FIFO occupancy
//   fifo_dout         FIFO read data
//   fifo_rd_en        one-cycle read request
//   out_valid         out_data holds a word
//   out_data          captured word
//   out_ready         downstream accepts when out_valid && out_ready
//   busy              controller not idle
//   rd_count          (FIFO_RDR_CNT_EN only) accepted-word count
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
`ifdef FIFO_RDR_CNT_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
    $error("fifo_reader: RD_LATENCY must be in 1..7");
  end

  rdr_state_e state;
  rdr_state_e next_state;
  wait_cnt_t  wait_cnt;

  fifo_rdr_ns #(
    .CNT_W(CNT_W)
  ) u_ns (
    .state           (state),
    .enable          (enable),
    .clear           (clear),
    .fifo_data_count (fifo_data_count),
    .out_ready       (out_ready),
    .wait_cnt        (wait_cnt),
    .next_state      (next_state)
  );

  // Outputs are decoded from next_state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      fifo_rd_en <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      fifo_rd_en <= (next_state == REQ);
      out_valid  <= (next_state == HOLD);
      busy       <= (next_state != IDLE);

      if (clear) begin
        wait_cnt <= '0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt_t'(RD_LATENCY);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - wait_cnt_t'(1);
      end

      // WAIT->HOLD only happens in the final latency cycle and never under
      // clear, so out_data keeps its old value on abort.
      if (state == WAIT && next_state == HOLD) begin
        out_data <= fifo_dout;
      end
    end
  end

`ifdef FIFO_RDR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
    end else if (clear) begin
      rd_count <= '0;
    end else if (out_valid && out_ready) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: self-checking bench for fifo_reader with a behavioural
// FIFO model (RD_LATENCY read pipeline) and a scoreboard of expected words.
module tb_fifo_reader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] JUNK   = 32'h0BAD_F00D;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  fifo_data_count = '0;
  logic [DATA_W-1:0] fifo_dout = JUNK;
  logic              fifo_rd_en;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
`ifdef FIFO_RDR_CNT_EN
  logic [15:0]       rd_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_err = 0;
  int acc_cnt = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          rd_times[$];
  logic        pv[0:RD_LAT];
  logic [31:0] pw[0:RD_LAT];

  fifo_reader #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .clear           (clear),
    .fifo_data_count (fifo_data_count),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .busy            (busy)
`ifdef FIFO_RDR_CNT_EN
    ,
    .rd_count        (rd_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: pops on rd_en, presents the word RD_LAT cycles later,
  // flags reads from an empty FIFO, empties on clear.
  always @(negedge clk) begin
    if (clear) begin
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i <= RD_LAT; i++) pv[i] = 1'b0;
    end else begin
      for (int i = RD_LAT; i > 0; i--) begin
        pv[i] = pv[i-1];
        pw[i] = pw[i-1];
      end
      pv[0] = 1'b0;
      pw[0] = JUNK;
      if (fifo_rd_en === 1'b1) begin
        if (fifo_q.size() == 0) begin
          rd_err++;
        end else begin
          pv[0] = 1'b1;
          pw[0] = fifo_q.pop_front();
          rd_times.push_back(cyc);
        end
      end
    end
    fifo_dout       = (pv[RD_LAT] === 1'b1) ? pw[RD_LAT] : JUNK;
    fifo_data_count = CNT_W'(fifo_q.size());
  end

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      acc_cnt++;
      check("sb_has_word", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag, input int max);
    bit done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // Waits (bounded) at negedges for fifo_rd_en (want_rd=1) or out_valid.
  task automatic wait_out(input string tag, input bit want_rd, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if ((want_rd ? fifo_rd_en : out_valid) === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int at;
    int bad;
    int rise;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // 1: three words back to back, rd_en pulses RD_LAT+2 apart
    @(posedge clk); #1;
    rd_times.delete();
    base = acc_cnt;
    push_word(32'hA1A1_0001);
    push_word(32'hA2A2_0002);
    push_word(32'hA3A3_0003);
    enable = 1'b1;
    out_ready = 1'b1;
    drain("t1_drain", 100);
    check("t1_accepts", 64'(acc_cnt - base), 64'd3);
    check("t1_rd_pulses", 64'(rd_times.size()), 64'd3);
    if (rd_times.size() == 3) begin
      check("t1_gap0", 64'(rd_times[1] - rd_times[0]), 64'(RD_LAT + 2));
      check("t1_gap1", 64'(rd_times[2] - rd_times[1]), 64'(RD_LAT + 2));
    end

    // 2: empty FIFO with enable high stays idle
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t2_idle", 64'(bad), 64'd0);
    check("t2_rd_err", 64'(rd_err), 64'd0);

    // 3: back-pressure holds the word; latency rd_en -> out_valid
    @(posedge clk); #1;
    out_ready = 1'b0;
    rd_times.delete();
    base = acc_cnt;
    push_word(32'hDEAD_BEEF);
    wait_out("t3_valid_seen", 1'b0, rise);
    check("t3_latency", 64'((rd_times.size() > 0) ? rise - rd_times[0] : -1), 64'(RD_LAT + 1));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === 32'hDEAD_BEEF)) bad++;
    end
    check("t3_hold", 64'(bad), 64'd0);
    check("t3_no_accept_yet", 64'(acc_cnt - base), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("t3_drain", 20);
    check("t3_accepts", 64'(acc_cnt - base), 64'd1);
    check("t3_out_valid_low", 64'(out_valid), 64'd0);

    // 4: clear in the WAIT cycle discards the in-flight read
    base = acc_cnt;
    push_word(32'h4444_0001);
    wait_out("t4_rd_seen", 1'b1, at);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_rd_en", 64'(fifo_rd_en), 64'd0);
    check("t4_out_data_kept", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t4_quiet", 64'(bad), 64'd0);
    check("t4_no_word", 64'(acc_cnt - base), 64'd0);
    @(posedge clk); #1;
    push_word(32'h4444_0002);
    push_word(32'h4444_0003);
    drain("t4_resume", 50);
    check("t4_resume_accepts", 64'(acc_cnt - base), 64'd2);

    // Full FIFO (count 8) and accepted-word counter
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
`ifdef FIFO_RDR_CNT_EN
    check("cnt_after_clear0", 64'(rd_count), 64'd0);
`endif
    base = acc_cnt;
    for (int i = 0; i < 8; i++) push_word(32'h8800_0000 + 32'(i));
    drain("full_drain", 100);
    check("full_accepts", 64'(acc_cnt - base), 64'd8);
`ifdef FIFO_RDR_CNT_EN
    check("cnt_eight", 64'(rd_count), 64'd8);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("cnt_cleared", 64'(rd_count), 64'd0);
`endif

    // 5: asynchronous reset mid-HOLD
    out_ready = 1'b0;
    push_word(32'h55AA_55AA);
    wait_out("t5_valid_seen", 1'b0, at);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_rd_en", 64'(fifo_rd_en), 64'd0);
    check("t5_out_data", 64'(out_data), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    base = acc_cnt;
    out_ready = 1'b1;
    push_word(32'h5555_0001);
    drain("t5_recover", 30);
    check("t5_recover_accepts", 64'(acc_cnt - base), 64'd1);

    check("rd_err_total", 64'(rd_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Consumer-side controller for the 8-deep, 32-bit FIFO: the read end of the FIFO's rd_en/dout/data_count interface.
- Watches the FIFO occupancy and issues single-cycle rd_en pulses, one read outstanding at a time.
- Captures the returned word after a fixed read latency.
- Presents the word downstream on a valid/ready stream.
- Sits between the FIFO and any downstream consumer in the TOP datapath.

Parameters:
DATA_W, 32, width of FIFO data and out_data.
CNT_W, 4, width of the FIFO data_count (depth 8, so values 0..8).
RD_LATENCY, 2, cycles from the rd_en cycle to the cycle in which fifo_dout is valid; legal range 1..7.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  allow new reads to start.
clear  in  1  synchronous abort; the same signal drives the FIFO opclear.
fifo_data_count  in  CNT_W  FIFO occupancy.
fifo_dout  in  DATA_W  FIFO read data.
fifo_rd_en  out  1  read request to the FIFO; one-cycle pulse.
out_valid  out  1  out_data holds a word.
out_data  out  DATA_W  captured word.
out_ready  in  1  downstream accepts the word when out_valid&&out_ready.
busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, wait counter=0.
  - fifo_rd_en=0, out_valid=0, out_data=0, busy=0.
- All state, counters and outputs are registered (Moore outputs); there are no combinational paths from inputs to outputs.
- States, 2 bits: IDLE=00, REQ=01, WAIT=10, HOLD=11.
- IDLE:
  - If !clear && enable && fifo_data_count!=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - fifo_rd_en=1 for exactly this cycle.
  - Wait counter is loaded with RD_LATENCY.
  - Always go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter==1, fifo_dout is latched into out_data and the next state is HOLD, with out_valid=1.
  - Deasserting enable during WAIT does not abort the read.
- HOLD:
  - out_valid=1; out_data is held stable until accepted.
  - On out_valid&&out_ready:
    - if enable && fifo_data_count!=0, go to REQ with out_valid=0;
    - otherwise go to IDLE with out_valid=0.
  - Without out_ready, stay in HOLD regardless of enable.
- Latency: fifo_rd_en in cycle t; out_valid rises at cycle t+RD_LATENCY+1.
- Throughput: with out_ready tied high, one word per RD_LATENCY+2 cycles (4 cycles at default).
- Over-read protection:
  - A new read is never issued before the previous read's data_count decrement is visible; the WAIT length ≥1 guarantees this.
  - fifo_rd_en is never asserted while fifo_data_count==0, so the FIFO never enters RD_ERROR because of this block.
- clear has priority over every transition. On the next edge:
  - state=IDLE, fifo_rd_en=0, out_valid=0;
  - out_data keeps its last value;
  - any in-flight read is discarded.
- Reset mid-operation: immediate return to the reset values; no partial word is emitted.
- fifo_data_count==8 (full) is treated like any other nonzero count.
- Width rules:
  - wait counter is 3 bits, unsigned;
  - out_data width equals DATA_W exactly, with no extension.

Optional Feature:
Macro: FIFO_RDR_CNT_EN
- Defined:
  - Adds output port rd_count, out, 16 bits: number of accepted words (out_valid&&out_ready).
  - Increments by 1 per accept and wraps from 0xFFFF to 0x0000.
  - Reset to 0 by reset_n=0 and by clear=1 (clear wins over a simultaneous accept).
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encodings IDLE/REQ/WAIT/HOLD;
  - FIFO_DEPTH=8;
  - default widths DATA_W=32, CNT_W=4.
- One sub-module, fifo_rdr_ns: purely combinational next-state logic.
  - Inputs: state, enable, clear, fifo_data_count, out_ready, wait counter.
  - Output: next_state.
- Registers and output logic stay in the top of fifo_reader.

Test Plan:
1. Reset, then FIFO preloaded with 3 words A1,A2,A3, enable=1, out_ready=1 -> three rd_en pulses exactly 4 cycles apart; out_data sequence A1,A2,A3; fifo_rd_en never asserted once data_count reaches 0.
2. Empty FIFO (data_count=0), enable=1 for 20 cycles -> fifo_rd_en stays 0, state stays IDLE, busy=0, FIFO never reports RD_ERROR.
3. One word 0xDEADBEEF, out_ready=0 for 10 cycles after out_valid rises -> out_valid=1 and out_data=0xDEADBEEF held all 10 cycles; after out_ready=1, exactly one accept, then IDLE.
4. clear pulsed in the WAIT cycle after rd_en -> next cycle IDLE, out_valid=0, no word emitted; with data reloaded and clear released, normal reads resume.
5. reset_n driven low asynchronously mid-HOLD -> out_valid, fifo_rd_en, out_data and busy read 0 before the next clock edge.
6. FIFO_RDR_CNT_EN defined, 8 words read with out_ready=1 -> rd_count=8; a clear pulse then sets rd_count=0.
